// File: rtl/bexkat1_pkg.sv
// Shared op/size codes and stage state for the bexkat1 pipeline.
// Also holds the access alignment helper used at acceptance.
package bexkat1_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  function automatic logic misaligned(
    input size_e      sz,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      sz == SZ_HALF: bad = off[0];
      sz == SZ_WORD: bad = |off;
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Big-endian byte-lane steering: select, store replication, load extract.
// Ports: off_i/size_i access shape, st_dat_i/bus_dat_i in, sel/dat/ld out.
import bexkat1_pkg::*;

module bus_lane_align (
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic [31:0] st_dat_i,
  input  logic [31:0] bus_dat_i,
  output logic [3:0]  sel_o,
  output logic [31:0] st_dat_o,
  output logic [31:0] ld_dat_o
);

  logic [31:0] b_sh;
  logic [31:0] h_sh;

  // Offset 0 is the most significant lane.
  assign b_sh = bus_dat_i >> {~off_i, 3'b000};
  assign h_sh = bus_dat_i >> {~off_i[1], 4'b0000};

  always_comb begin
    sel_o    = 4'b0000;
    st_dat_o = 32'h0;
    ld_dat_o = 32'h0;
    unique case (1'b1)
      size_i == SZ_BYTE: begin
        sel_o    = 4'b1000 >> off_i;
        st_dat_o = {4{st_dat_i[7:0]}};
        ld_dat_o = {24'h0, b_sh[7:0]};
      end
      size_i == SZ_HALF: begin
        sel_o    = off_i[1] ? 4'b0011 : 4'b1100;
        st_dat_o = {2{st_dat_i[15:0]}};
        ld_dat_o = {16'h0, h_sh[15:0]};
      end
      size_i == SZ_WORD: begin
        sel_o    = 4'b1111;
        st_dat_o = st_dat_i;
        ld_dat_o = bus_dat_i;
      end
      default: begin
        sel_o    = 4'b0000;
        st_dat_o = 32'h0;
        ld_dat_o = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/memwb_stage.sv
// Memory + writeback stage: one bus access per op, then a 1-cycle WB.
// Ports: valid/ready in, op/size/addr/data/rd/sp, bus master, rf writes.
import bexkat1_pkg::*;

module memwb_stage #(
  parameter int WIDTH  = 32,
  parameter int COUNTP = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        op_i,
  input  logic [1:0]        size_i,
  input  logic [WIDTH-1:0]  addr_i,
  input  logic [WIDTH-1:0]  result_i,
  input  logic [WIDTH-1:0]  store_i,
  input  logic [COUNTP-1:0] rd_i,
  input  logic              rd_we_i,
  input  logic [WIDTH-1:0]  sp_i,
  input  logic              sp_we_i,
  output logic [COUNTP-1:0] write_addr,
  output logic [WIDTH-1:0]  write_data,
  output logic [1:0]        write_en,
  output logic [WIDTH-1:0]  sp_data,
  output logic [1:0]        sp_en,
  output logic              bus_cyc,
  output logic              bus_stb,
  output logic              bus_we,
  output logic [WIDTH-1:0]  bus_adr,
  output logic [WIDTH-1:0]  bus_dat_o,
  output logic [3:0]        bus_sel,
  input  logic [WIDTH-1:0]  bus_dat_i,
  input  logic              bus_ack,
  input  logic              bus_err,
  output logic              fault_o
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  size_e  size_q, size_d;

  logic [WIDTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  st_q, st_d;
  logic [WIDTH-1:0]  sp_q, sp_d;
  logic [WIDTH-1:0]  ld_q, ld_d;
  logic [COUNTP-1:0] rd_q, rd_d;
  logic              rd_we_q, rd_we_d;
  logic              sp_we_q, sp_we_d;
  logic              fault_q, fault_d;

  logic       accept;
  logic       in_bus;
  logic       in_wb;
  op_e        op_in;
  logic [3:0] sel_w;
  logic [WIDTH-1:0] st_w;
  logic [WIDTH-1:0] ld_w;

  assign ready_o = (state_q == ST_IDLE);
  assign accept  = valid_i && ready_o;
  assign in_bus  = (state_q == ST_BUS);
  assign in_wb   = (state_q == ST_WB);

  // Reserved op collapses to NONE before it reaches state.
  assign op_in = (op_e'(op_i) == OP_RSVD)
               ? OP_NONE : op_e'(op_i);

  bus_lane_align u_align (
    .off_i     (addr_q[1:0]),
    .size_i    (size_q),
    .st_dat_i  (st_q),
    .bus_dat_i (bus_dat_i),
    .sel_o     (sel_w),
    .st_dat_o  (st_w),
    .ld_dat_o  (ld_w)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    size_d  = size_q;
    addr_d  = addr_q;
    res_d   = res_q;
    st_d    = st_q;
    sp_d    = sp_q;
    ld_d    = ld_q;
    rd_d    = rd_q;
    rd_we_d = rd_we_q;
    sp_we_d = sp_we_q;
    fault_d = 1'b0;

    if (accept) begin
      op_d    = op_in;
      size_d  = size_e'(size_i);
      addr_d  = addr_i;
      res_d   = result_i;
      st_d    = store_i;
      sp_d    = sp_i;
      rd_d    = rd_i;
      rd_we_d = rd_we_i;
      sp_we_d = sp_we_i;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_in == OP_NONE) begin
            state_d = ST_WB;
          end else if (misaligned(size_e'(size_i),
                                  addr_i[1:0])) begin
            fault_d = 1'b1;
          end else begin
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        // Error wins over a coincident ack.
        if (bus_err) begin
          state_d = ST_IDLE;
          fault_d = 1'b1;
        end else if (bus_ack) begin
          state_d = ST_WB;
          ld_d    = ld_w;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      size_q  <= SZ_NONE;
      addr_q  <= '0;
      res_q   <= '0;
      st_q    <= '0;
      sp_q    <= '0;
      ld_q    <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
      sp_we_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      res_q   <= res_d;
      st_q    <= st_d;
      sp_q    <= sp_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      rd_we_q <= rd_we_d;
      sp_we_q <= sp_we_d;
      fault_q <= fault_d;
    end
  end

  assign fault_o = fault_q;

  assign bus_cyc   = in_bus;
  assign bus_stb   = in_bus;
  assign bus_we    = in_bus && (op_q == OP_STORE);
  assign bus_adr   = in_bus ? addr_q : '0;
  assign bus_sel   = in_bus ? sel_w : 4'b0000;
  assign bus_dat_o = in_bus ? st_w : '0;

  always_comb begin
    write_en = 2'd0;
    if (in_wb && rd_we_q) begin
      write_en = (op_q == OP_LOAD) ? 2'(size_q) : 2'd3;
    end
  end

  assign write_addr = in_wb ? rd_q : '0;
  assign write_data = !in_wb ? '0
                    : (op_q == OP_LOAD) ? ld_q : res_q;

  assign sp_en   = (in_wb && sp_we_q) ? 2'd3 : 2'd0;
  assign sp_data = (in_wb && sp_we_q) ? sp_q : '0;

endmodule

// File: tb/tb_memwb_stage.sv
// Self-checking bench for memwb_stage: directed cases plus random ops.
// Acts as bus slave; expectations come from a transaction-level model.
module tb_memwb_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  op_i = 2'd0;
  logic [1:0]  size_i = 2'd0;
  logic [31:0] addr_i = '0;
  logic [31:0] result_i = '0;
  logic [31:0] store_i = '0;
  logic [3:0]  rd_i = '0;
  logic        rd_we_i = 1'b0;
  logic [31:0] sp_i = '0;
  logic        sp_we_i = 1'b0;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic [1:0]  write_en;
  logic [31:0] sp_data;
  logic [1:0]  sp_en;
  logic        bus_cyc, bus_stb, bus_we;
  logic [31:0] bus_adr, bus_dat_o;
  logic [3:0]  bus_sel;
  logic [31:0] bus_dat_i = '0;
  logic        bus_ack = 1'b0;
  logic        bus_err = 1'b0;
  logic        fault_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  memwb_stage #(.WIDTH(32), .COUNTP(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .size_i(size_i),
    .addr_i(addr_i), .result_i(result_i),
    .store_i(store_i), .rd_i(rd_i),
    .rd_we_i(rd_we_i), .sp_i(sp_i),
    .sp_we_i(sp_we_i),
    .write_addr(write_addr),
    .write_data(write_data),
    .write_en(write_en), .sp_data(sp_data),
    .sp_en(sp_en), .bus_cyc(bus_cyc),
    .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_adr(bus_adr), .bus_dat_o(bus_dat_o),
    .bus_sel(bus_sel), .bus_dat_i(bus_dat_i),
    .bus_ack(bus_ack), .bus_err(bus_err),
    .fault_o(fault_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Big-endian lane model: offset 0 is the top byte.
  function automatic logic [3:0] m_sel(
    input int sz, input int off);
    if (sz == 1) return 4'(1 << (3 - off));
    if (sz == 2) return (off >= 2) ? 4'h3 : 4'hC;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_st(
    input int sz, input logic [31:0] d);
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(
    input int sz, input int off, input logic [31:0] d);
    if (sz == 1) return (d >> (8 * (3 - off))) & 32'hFF;
    if (sz == 2)
      return (d >> ((off >= 2) ? 0 : 16)) & 32'hFFFF;
    return d;
  endfunction

  function automatic bit m_mis(
    input int sz, input logic [31:0] a);
    if (sz == 2) return (a % 2) != 0;
    if (sz == 3) return (a % 4) != 0;
    return 1'b0;
  endfunction

  task automatic scramble();
    op_i     = 2'($urandom);
    size_i   = 2'($urandom);
    addr_i   = $urandom;
    result_i = $urandom;
    store_i  = $urandom;
    rd_i     = 4'($urandom);
    rd_we_i  = 1'($urandom);
    sp_i     = $urandom;
    sp_we_i  = 1'($urandom);
  endtask

  task automatic wb_chk(input int op, input int sz,
                        input logic [3:0] rd,
                        input logic rwe,
                        input logic [31:0] wd,
                        input logic swe,
                        input logic [31:0] sp);
    int we;
    we = !rwe ? 0 : (op == 1) ? sz : 3;
    chk("wb_en", 32'(write_en), 32'(we));
    if (rwe) begin
      chk("wb_addr", 32'(write_addr), 32'(rd));
      chk("wb_data", write_data, wd);
    end
    chk("wb_spen", 32'(sp_en), swe ? 32'd3 : 32'd0);
    if (swe) chk("wb_sp", sp_data, sp);
    chk("wb_cyc", 32'(bus_cyc), 0);
    chk("wb_fault", 32'(fault_o), 0);
    chk("wb_rdy", 32'(ready_o), 0);
    step();
    chk("post_en", 32'(write_en), 0);
    chk("post_spen", 32'(sp_en), 0);
    chk("post_rdy", 32'(ready_o), 1);
  endtask

  task automatic txn(input logic [1:0] op,
                     input logic [1:0] sz,
                     input logic [31:0] adr,
                     input logic [31:0] res,
                     input logic [31:0] st,
                     input logic [3:0] rd,
                     input logic rwe,
                     input logic [31:0] sp,
                     input logic swe,
                     input int wt,
                     input logic err,
                     input logic err_ack,
                     input logic [31:0] rdat);
    int eop, off;
    eop = (op == 2'd3) ? 0 : int'(op);
    off = int'(adr[1:0]);
    chk("rdy", 32'(ready_o), 1);
    op_i = op; size_i = sz; addr_i = adr;
    result_i = res; store_i = st; rd_i = rd;
    rd_we_i = rwe; sp_i = sp; sp_we_i = swe;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    scramble();
    if (eop == 0) begin
      wb_chk(0, int'(sz), rd, rwe, res, swe, sp);
    end else if (m_mis(int'(sz), adr)) begin
      chk("mis_fault", 32'(fault_o), 1);
      chk("mis_cyc", 32'(bus_cyc), 0);
      chk("mis_en", 32'(write_en), 0);
      chk("mis_rdy", 32'(ready_o), 1);
      step();
      chk("mis_fault2", 32'(fault_o), 0);
    end else begin
      for (int i = 0; i <= wt; i++) begin
        chk("bus_cyc", 32'(bus_cyc), 1);
        chk("bus_stb", 32'(bus_stb), 1);
        chk("bus_we", 32'(bus_we), 32'(eop == 2));
        chk("bus_adr", bus_adr, adr);
        chk("bus_sel", 32'(bus_sel),
            32'(m_sel(int'(sz), off)));
        if (eop == 2)
          chk("bus_dat", bus_dat_o, m_st(int'(sz), st));
        chk("bus_en", 32'(write_en), 0);
        chk("bus_rdy", 32'(ready_o), 0);
        if (i < wt) begin
          bus_dat_i = $urandom;
          step();
        end
      end
      bus_ack = !err || err_ack;
      bus_err = err;
      bus_dat_i = rdat;
      step();
      bus_ack = 1'b0;
      bus_err = 1'b0;
      bus_dat_i = $urandom;
      if (err) begin
        chk("err_fault", 32'(fault_o), 1);
        chk("err_en", 32'(write_en), 0);
        chk("err_spen", 32'(sp_en), 0);
        chk("err_cyc", 32'(bus_cyc), 0);
        chk("err_rdy", 32'(ready_o), 1);
        step();
        chk("err_fault2", 32'(fault_o), 0);
        chk("err_en2", 32'(write_en), 0);
      end else begin
        wb_chk(eop, int'(sz), rd, rwe,
               (eop == 1) ? m_ld(int'(sz), off, rdat) : res,
               swe, sp);
      end
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_rdy", 32'(ready_o), 1);
    chk("rst_en", 32'(write_en), 0);
    chk("rst_spen", 32'(sp_en), 0);
    chk("rst_cyc", 32'(bus_cyc), 0);
    chk("rst_stb", 32'(bus_stb), 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_fault", 32'(fault_o), 0);
    chk("rst_wd", write_data, 0);
    chk("rst_adr", bus_adr, 0);
    rst_i = 1'b1;

    txn(2'd0, 2'd3, 32'h0, 32'h12345678, 32'h0,
        4'd3, 1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    txn(2'd1, 2'd1, 32'h1001, 32'h0, 32'h0,
        4'd5, 1'b1, 32'h0, 1'b0, 3, 1'b0, 1'b0,
        32'hAABBCCDD);
    txn(2'd2, 2'd2, 32'h2002, 32'h0, 32'h0000BEEF,
        4'd1, 1'b0, 32'h0, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    txn(2'd1, 2'd3, 32'h3001, 32'h0, 32'h0,
        4'd6, 1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    txn(2'd1, 2'd3, 32'h3000, 32'h0, 32'h0,
        4'd6, 1'b1, 32'h0, 1'b1, 0, 1'b1, 1'b1,
        32'h55AA55AA);
    txn(2'd1, 2'd3, 32'h4000, 32'h0, 32'h0,
        4'd2, 1'b1, 32'h7FF0, 1'b1, 1, 1'b0, 1'b0,
        32'hCAFEF00D);
    txn(2'd3, 2'd1, 32'h5003, 32'hDEADBEEF, 32'h0,
        4'd9, 1'b1, 32'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a bus cycle.
    addr_i = 32'h6000; op_i = 2'd1; size_i = 2'd3;
    rd_i = 4'd4; rd_we_i = 1'b1; sp_we_i = 1'b1;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("pre_rst_cyc", 32'(bus_cyc), 1);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(bus_cyc), 0);
    chk("mid_rst_rdy", 32'(ready_o), 1);
    chk("mid_rst_fault", 32'(fault_o), 0);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("after_rst_en", 32'(write_en), 0);
      chk("after_rst_spen", 32'(sp_en), 0);
      chk("after_rst_fault", 32'(fault_o), 0);
      if (i == 0) begin
        txn(2'd0, 2'd3, 32'h0, 32'h0BADF00D, 32'h0,
            4'd7, 1'b1, 32'h1234, 1'b1, 0,
            1'b0, 1'b0, 32'h0);
      end else begin
        step();
      end
    end

    for (int n = 0; n < 300; n++) begin
      logic [1:0]  op, sz;
      logic [31:0] adr;
      logic        err;
      op  = 2'($urandom);
      sz  = 2'($urandom_range(3, 1));
      adr = $urandom;
      if ($urandom_range(3, 0) != 0)
        adr[1:0] = (sz == 2'd3) ? 2'd0
                 : (sz == 2'd2) ? {adr[1], 1'b0}
                 : adr[1:0];
      err = ($urandom_range(5, 0) == 0);
      txn(op, sz, adr, $urandom, $urandom,
          4'($urandom), 1'($urandom), $urandom,
          1'($urandom), $urandom_range(4, 0), err,
          1'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memwb_stage.md
MEMWB_STAGE -- requirements
Module: memwb_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath and bus width; only 32 is supported.
REQ-002 SHALL have parameter COUNTP, default 4, register address width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports valid_i input 1 and ready_o output 1: the execute-to-stage handshake.
REQ-006 SHALL have port op_i  input  2  operation: NONE=0, LOAD=1, STORE=2; 3 is reserved and treated as NONE.
REQ-007 SHALL have port size_i  input  2  access/write size: 1=byte, 2=half, 3=word.
REQ-008 SHALL have ports addr_i, result_i, store_i  input  WIDTH each: memory address, ALU result, store data.
REQ-009 SHALL have ports rd_i input COUNTP and rd_we_i input 1: destination register and its write request.
REQ-010 SHALL have ports sp_i input WIDTH and sp_we_i input 1: new stack-pointer value and its write request.
REQ-011 SHALL have register-file outputs write_addr (COUNTP), write_data (WIDTH), write_en (2), sp_data (WIDTH) and sp_en (2).
REQ-012 SHALL have bus ports bus_cyc, bus_stb, bus_we (output 1 each), bus_adr and bus_dat_o (output WIDTH), bus_sel (output 4), bus_dat_i (input WIDTH), and bus_ack, bus_err (input 1 each).
REQ-013 SHALL have port fault_o  output  1  one-cycle pulse on a bus error or misalignment.

Function
REQ-014 SHALL implement FSM states IDLE, BUS, WB; ready_o = (state==IDLE).
REQ-015 A transfer SHALL occur when valid_i && ready_o; all inputs are captured into internal registers on that edge.
REQ-016 Accepting NONE SHALL go IDLE->WB; WB SHALL last exactly one cycle and then return to IDLE.
REQ-017 Accepting an aligned LOAD or STORE SHALL go IDLE->BUS; bus_cyc=bus_stb=1 SHALL be held with stable address, select and data until bus_ack or bus_err.
REQ-018 bus_ack in BUS SHALL go to WB. bus_err in BUS SHALL go to IDLE, pulse fault_o and suppress all register writes; bus_err SHALL take priority when it coincides with bus_ack.
REQ-019 Misalignment (half with addr[0]=1, word with addr[1:0]!=0) SHALL go IDLE->IDLE with a fault_o pulse, no bus cycle and no register writes.
REQ-020 Byte lanes are big-endian: byte at offset 0 uses bus_sel=4'b1000 and bits 31:24; half at offset 0 uses 4'b1100; word uses 4'b1111.
REQ-021 Store data SHALL be replicated onto the lanes selected by bus_sel.
REQ-022 Load data SHALL be shifted to the low bits, with the unused upper bits driven to zero, and bus_dat_i SHALL be latched on the edge where ack is seen.
REQ-023 In WB only, write_en SHALL equal size for a LOAD with rd_we, 3 for a NONE or STORE with rd_we, and 0 otherwise.
REQ-024 write_data SHALL be the aligned load data for a LOAD and result_i otherwise.
REQ-025 In WB, sp_en SHALL be 3 and sp_data SHALL be sp_i if sp_we was captured; otherwise sp_en SHALL be 0.
REQ-026 Register and stack-pointer writes SHALL be issued in the same WB cycle; the register file resolves rd==SP ordering.
REQ-027 Latency SHALL be: NONE accepted at edge N writes at N+1; LOAD/STORE writes one cycle after the ack edge.
REQ-028 Outside WB, write_en and sp_en SHALL be 0; outside BUS, bus_cyc, bus_stb and bus_we SHALL be 0.

Reset
REQ-029 Asserting rst_i SHALL immediately force state=IDLE and drive all outputs to 0 except ready_o, which SHALL be 1.
REQ-030 Reset during BUS SHALL drop bus_cyc immediately, discard the pending write, and leave no fault_o pulse.
REQ-031 The first transfer SHALL be accepted on the first clock edge after rst_i deasserts.

Structure
REQ-032 The op codes, size codes and FSM state enum SHALL live in the shared package bexkat1_pkg.
REQ-033 Lane select, store replication and load extraction SHALL be one combinational sub-module, bus_lane_align.

Verification
REQ-034 NONE, rd=3, result=0x12345678 -> write_en=3, write_addr=3, write_data=0x12345678 one cycle after acceptance.
REQ-035 LOAD byte at addr 0x1001, bus_dat_i=0xAABBCCDD, ack after 3 cycles -> bus_sel=0100, then write_data=0x000000BB with write_en=1.
REQ-036 STORE half at addr 0x2002, store=0x0000BEEF -> bus_sel=0011, bus_dat_o=0xBEEFBEEF, bus_we=1, write_en=0.
REQ-037 LOAD word at addr 0x3001 -> fault_o pulses and no bus_cyc; LOAD with bus_err and bus_ack together -> fault_o pulses and write_en stays 0.
REQ-038 LOAD with rd_we, rd=2 and sp_we, sp=0x7FF0 -> write_en=3 and sp_en=3 in the same cycle.
REQ-039 rst_i asserted while in BUS -> bus_cyc=0 the same cycle, ready_o=1, and no later write.
